gje_sequencer: RTL and testbench

GJE_SEQUENCER -- requirements
Module: gje_sequencer

---
 rtl/gje_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_gje_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gje_sequencer.sv
// gje_sequencer: 5x5 Gauss-Jordan elimination sequencer over a 5x10 augmented
// register array using a single shared multiply-subtract unit r = x*p - y*f.
// Results are unnormalised (each row scaled by its accumulated pivot product).
// Optional feature macro: GJE_SEQUENCER_DET_EN adds a 4-cycle DET state that
// multiplies the forward-phase diagonal into det; otherwise det is tied to 0.
module gje_sequencer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [W-1:0] det,
    output logic         busy,
    output logic         singular
);

    typedef enum logic [3:0] {
        IDLE, LOAD, FPIV, FROW, FCOL, BPIV, BROW, BCOL,
`ifdef GJE_SEQUENCER_DET_EN
        DET,
`endif
        OUT
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] m_q [0:4][0:9];
    logic [2:0]   k_q;
    logic [2:0]   i_q;
    logic [3:0]   j_q;
    logic [W-1:0] p_q;
    logic [W-1:0] f_q;
    logic         singular_q;

    logic         inXfer, outXfer, lastCol, lastBeat;
    logic [W-1:0] mulX, mulY, mulP, mulF, mulR;

`ifdef GJE_SEQUENCER_DET_EN
    logic [W-1:0] diag_q [0:4];
    logic [W-1:0] det_q;
`endif

    assign inXfer   = in_valid && in_ready;
    assign outXfer  = out_valid && out_ready;
    assign lastCol  = (j_q == 4'd9);
    assign lastBeat = (i_q == 3'd4) && (j_q == 4'd4);

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? m_q[i_q][4'd5 + j_q] : '0;
    assign singular  = singular_q;

    // Shared multiply-subtract unit: row elimination normally, running det product in DET
    always_comb begin
        mulX = m_q[i_q][j_q];
        mulY = m_q[k_q][j_q];
        mulP = p_q;
        mulF = f_q;
`ifdef GJE_SEQUENCER_DET_EN
        if (state_q == DET) begin
            mulX = (j_q == 4'd0) ? diag_q[0] : det_q;
            mulP = diag_q[j_q[2:0] + 3'd1];
            mulY = '0;
            mulF = '0;
        end
`endif
        mulR = mulX * mulP - mulY * mulF;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state sequencing through load, forward pass, backward pass and output
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (inXfer) state_d = LOAD;
            LOAD: if (inXfer && lastBeat) state_d = FPIV;
            FPIV: state_d = (m_q[k_q][{1'b0, k_q}] == '0) ? IDLE : FROW;
            FROW: state_d = FCOL;
            FCOL: if (lastCol) begin
                if (i_q != 3'd4)      state_d = FROW;
                else if (k_q == 3'd3) state_d = BPIV;
                else                  state_d = FPIV;
            end
            BPIV: state_d = BROW;
            BROW: state_d = BCOL;
            BCOL: if (lastCol) begin
                if (i_q != k_q - 3'd1) state_d = BROW;
                else if (k_q != 3'd1)  state_d = BPIV;
`ifdef GJE_SEQUENCER_DET_EN
                else                   state_d = DET;
`else
                else                   state_d = OUT;
`endif
            end
`ifdef GJE_SEQUENCER_DET_EN
            DET:  if (j_q == 4'd3) state_d = OUT;
`endif
            OUT:  if (outXfer && lastBeat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Matrix array, loop counters, pivot/factor latches and the singular flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        <= '{default: '0};
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            p_q        <= '0;
            f_q        <= '0;
            singular_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: if (inXfer) begin
                    if (state_q == IDLE) singular_q <= 1'b0;
                    m_q[i_q][j_q]        <= in_data;
                    m_q[i_q][4'd5 + j_q] <= (i_q == j_q[2:0]) ? W'(1) : '0;
                    k_q <= '0;
                    if (j_q == 4'd4) begin
                        j_q <= '0;
                        i_q <= (i_q == 3'd4) ? 3'd0 : i_q + 3'd1;
                    end else begin
                        j_q <= j_q + 4'd1;
                    end
                end
                FPIV: begin
                    p_q <= m_q[k_q][{1'b0, k_q}];
                    if (m_q[k_q][{1'b0, k_q}] == '0) begin
                        singular_q <= 1'b1;
                        k_q <= '0;
                        i_q <= '0;
                        j_q <= '0;
                    end else begin
                        i_q <= k_q + 3'd1;
                    end
                end
                FROW, BROW: begin
                    f_q <= m_q[i_q][{1'b0, k_q}];
                    j_q <= '0;
                end
                FCOL: begin
                    m_q[i_q][j_q] <= mulR;
                    if (lastCol) begin
                        j_q <= '0;
                        if (i_q != 3'd4) i_q <= i_q + 3'd1;
                        else             k_q <= k_q + 3'd1;
                    end else begin
                        j_q <= j_q + 4'd1;
                    end
                end
                BPIV: begin
                    p_q <= m_q[k_q][{1'b0, k_q}];
                    i_q <= '0;
                end
                BCOL: begin
                    m_q[i_q][j_q] <= mulR;
                    if (lastCol) begin
                        j_q <= '0;
                        if (i_q != k_q - 3'd1) begin
                            i_q <= i_q + 3'd1;
                        end else if (k_q != 3'd1) begin
                            k_q <= k_q - 3'd1;
                        end else begin
                            k_q <= '0;
                            i_q <= '0;
                        end
                    end else begin
                        j_q <= j_q + 4'd1;
                    end
                end
`ifdef GJE_SEQUENCER_DET_EN
                DET: j_q <= (j_q == 4'd3) ? 4'd0 : j_q + 4'd1;
`endif
                OUT: if (outXfer) begin
                    if (j_q == 4'd4) begin
                        j_q <= '0;
                        i_q <= (i_q == 3'd4) ? 3'd0 : i_q + 3'd1;
                    end else begin
                        j_q <= j_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GJE_SEQUENCER_DET_EN
    // Capture the post-forward diagonal and fold it into det during DET
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_q <= '{default: '0};
            det_q  <= '0;
        end else begin
            if (state_q == IDLE && inXfer)      det_q <= '0;
            if (state_q == FPIV)                diag_q[k_q] <= m_q[k_q][{1'b0, k_q}];
            if (state_q == BPIV && k_q == 3'd4) diag_q[4] <= m_q[4][4];
            if (state_q == DET)                 det_q <= mulR;
        end
    end
    assign det = det_q;
`else
    assign det = '0;
`endif

endmodule

// File: tb/tb_gje_sequencer.sv
// tb_gje_sequencer: table-driven directed test of gje_sequencer plus hand-written
// sequences for ready toggling, in_valid held during compute and mid-run resets.
module tb_gje_sequencer;

    localparam int W = 20;
`ifdef GJE_SEQUENCER_DET_EN
    localparam int           LAT  = 233;
    localparam logic [W-1:0] DET1 = 1;
    localparam logic [W-1:0] DET2 = 2;
`else
    localparam int           LAT  = 229;
    localparam logic [W-1:0] DET1 = 0;
    localparam logic [W-1:0] DET2 = 0;
`endif

    typedef logic [24:0][W-1:0] mat_t;
    typedef struct packed {
        mat_t         a;
        mat_t         b;
        logic         sing;
        logic [15:0]  lat;
        logic [W-1:0] det;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] det;
    logic         busy;
    logic         singular;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    gje_sequencer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .det(det), .busy(busy), .singular(singular)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic mat_t ident();
        mat_t m;
        m = '0;
        for (int r = 0; r < 5; r++) m[5'(r * 6)] = W'(1);
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic resetCheck(input string tag);
        checkFlag({tag, " in_ready"}, in_ready, 1'b1);
        checkFlag({tag, " busy"}, busy, 1'b0);
        checkFlag({tag, " out_valid"}, out_valid, 1'b0);
        checkFlag({tag, " singular"}, singular, 1'b0);
        checkOutput({tag, " det"}, det, '0);
        checkOutput({tag, " out_data"}, out_data, '0);
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        resetCheck(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents n beats back to back; t0 is the cycle stamp of the last beat
    task automatic loadBeats(input mat_t a, input int n, output int t0);
        t0 = 0;
        for (int b = 0; b < n; b++) begin
            in_valid = 1'b1;
            in_data  = a[5'(b)];
            checkFlag($sformatf("in_ready beat%0d", b), in_ready, 1'b1);
            t0 = cyc;
            @(posedge clk);
            #1;
            if (b == 0) checkFlag("singular cleared on first beat", singular, 1'b0);
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input bit toggle, input bit holdValid, input string tag);
        int t0, lat, n;
        mat_t got;
        logic [W-1:0] heldVal;
        bit heldValid, ph, sawOut;
        got = '0; heldVal = '0; heldValid = 0; ph = 0; sawOut = 0; n = 0;
        out_ready = 1'b1;
        loadBeats(v.a, 25, t0);
        if (holdValid) begin
            in_valid = 1'b1;
            in_data  = '1;
        end
        lat = -1;
        for (int c = 0; c < 400; c++) begin
            if (out_valid || !busy) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput({tag, " latency"}, W'(lat), W'(v.lat));
        if (v.sing) begin
            checkFlag({tag, " singular"}, singular, 1'b1);
            for (int c = 0; c < 20; c++) begin
                if (out_valid) sawOut = 1;
                @(posedge clk);
                #1;
            end
            checkFlag({tag, " no out_valid"}, sawOut, 1'b0);
            checkOutput({tag, " det"}, det, '0);
        end else begin
            checkFlag({tag, " singular"}, singular, 1'b0);
            for (int c = 0; c < 200 && n < 25; c++) begin
                out_ready = toggle ? !ph : 1'b1;
                ph = !ph;
                if (out_valid) begin
                    if (heldValid) checkOutput($sformatf("%s hold beat%0d", tag, n), out_data, heldVal);
                    heldValid = 0;
                    if (out_ready) begin
                        got[5'(n)] = out_data;
                        n++;
                    end else begin
                        heldVal   = out_data;
                        heldValid = 1;
                    end
                end
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            checkOutput({tag, " beat count"}, W'(n), W'(25));
            for (int i = 0; i < 25; i++)
                checkOutput($sformatf("%s b%0d%0d", tag, i / 5 + 1, i % 5 + 1), got[5'(i)], v.b[5'(i)]);
            checkOutput({tag, " det"}, det, v.det);
            checkFlag({tag, " done busy"}, busy, 1'b0);
            checkFlag({tag, " done out_valid"}, out_valid, 1'b0);
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t v, vId;
        mat_t id;
        int t0;
        logic [W-1:0] neg3, neg5;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        neg3 = -W'(3);
        neg5 = -W'(5);
        id   = ident();

        // identity
        v.a = id; v.b = id; v.sing = 0; v.lat = 16'(LAT); v.det = DET1;
        vecs[0] = v; vId = v;
        // diag(1,1,1,1,2): backward pivots accumulate 2,2,4,16 into rows above
        v.a = id; v.a[24] = W'(2);
        v.b = '0; v.b[0] = W'(256); v.b[6] = W'(16); v.b[12] = W'(4); v.b[18] = W'(2); v.b[24] = W'(1);
        v.sing = 0; v.lat = 16'(LAT); v.det = DET2;
        vecs[1] = v;
        // all-zero: singular at first forward pivot
        v.a = '0; v.b = '0; v.sing = 1; v.lat = 16'd2; v.det = '0;
        vecs[2] = v;
        // a21 = 3
        v.a = id; v.a[5] = W'(3); v.b = id; v.b[5] = neg3;
        v.sing = 0; v.lat = 16'(LAT); v.det = DET1;
        vecs[3] = v;
        // a22 = 0: singular at second forward pivot (1 + 45 cycles later)
        v.a = id; v.a[6] = '0; v.b = '0; v.sing = 1; v.lat = 16'd47; v.det = '0;
        vecs[4] = v;
        // a21 = 3, a15 = 5
        v.a = id; v.a[5] = W'(3); v.a[4] = W'(5);
        v.b = id; v.b[4] = neg5; v.b[5] = neg3; v.b[9] = W'(15);
        v.sing = 0; v.lat = 16'(LAT); v.det = DET1;
        vecs[5] = v;

        repeat (2) @(posedge clk);
        #1;
        resetCheck("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        resetCheck("idle");

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

        applyStimulus(vId, 1'b1, 1'b0, "toggle");
        applyStimulus(vId, 1'b0, 1'b1, "holdIn");

        loadBeats(vecs[3].a, 25, t0);
        repeat (100) @(posedge clk);
        #1;
        doReset("rstCompute");
        applyStimulus(vId, 1'b0, 1'b0, "afterRstCompute");

        loadBeats(vecs[1].a, 10, t0);
        doReset("rstLoad");
        applyStimulus(vId, 1'b0, 1'b0, "afterRstLoad");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
